// File: rtl/rv_fifo_pkg.sv
// Shared defaults and address helpers for the rv_fifo family.
// Pointer arithmetic supports non-power-of-two depths.
package rv_fifo_pkg;

    localparam int RV_FIFO_WIDTH_DEF = 8;
    localparam int RV_FIFO_DEPTH_DEF = 10;

    function automatic int rv_fifo_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned rv_fifo_wrap_inc(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// Simple dual-port storage: port1 writes, port2 reads synchronously (registered output).
// A read and a write to the same address on one edge return the old contents.
module rv_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             port1_write_en,
    input  logic [AW-1:0]    port1_addr,
    input  logic [WIDTH-1:0] port1_data,
    input  logic [AW-1:0]    port2_addr,
    output logic [WIDTH-1:0] port2_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (port1_write_en) begin
            mem_q[port1_addr] <= port1_data;
        end
        rd_dat_q <= mem_q[port2_addr];
    end

    assign port2_data = rd_dat_q;

endmodule

// File: rtl/rv_fifo_level.sv
// Ready/valid FIFO with occupancy count and registered almost-full/almost-empty flags.
// Latency 1 cycle (0 with RV_FIFO_BYPASS_EN on an empty FIFO); ready = ~full, valid never depends on ready.
module rv_fifo_level
    import rv_fifo_pkg::*;
#(
    parameter int WIDTH              = RV_FIFO_WIDTH_DEF,
    parameter int DEPTH              = RV_FIFO_DEPTH_DEF,
    parameter int ALMOST_FULL_LEVEL  = 8,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                       clock_port,
    input  logic                       reset_port,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           input_port_data,
    input  logic                       input_port_valid,
    output logic                       input_port_ready,
    output logic [WIDTH-1:0]           output_port_data,
    output logic                       output_port_valid,
    input  logic                       output_port_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int AW = rv_fifo_addr_w(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [AW-1:0]    push_addr_q, push_addr_d;
    logic [AW-1:0]    pop_addr_q, pop_addr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;
    logic             fwd_sel_q, fwd_sel_d;
    logic [WIDTH-1:0] fwd_dat_q, fwd_dat_d;
    logic             push, pop, bypass_take, mem_wr_en;
    logic [WIDTH-1:0] mem_rd_dat, stored_dat;

    always_comb begin
`ifdef RV_FIFO_BYPASS_EN
        bypass_take = empty_q & input_port_valid & output_port_ready;
`else
        bypass_take = 1'b0;
`endif
        push      = input_port_valid & ~full_q & ~bypass_take;
        pop       = ~empty_q & output_port_ready;
        mem_wr_en = push & ~clear & ~reset_port;

        push_addr_d = push_addr_q;
        pop_addr_d  = pop_addr_q;
        level_d     = level_q;
        fwd_sel_d   = 1'b0;
        fwd_dat_d   = input_port_data;
        if (clear) begin
            push_addr_d = '0;
            pop_addr_d  = '0;
            level_d     = '0;
        end else begin
            if (push) push_addr_d = AW'(rv_fifo_wrap_inc(32'(push_addr_q), DEPTH));
            if (pop)  pop_addr_d  = AW'(rv_fifo_wrap_inc(32'(pop_addr_q), DEPTH));
            level_d = level_q + LW'(push) - LW'(pop);
            // The synchronous read returns the old word when it targets the slot being written now.
            fwd_sel_d = push & (push_addr_q == pop_addr_d);
        end

        empty_d        = (level_d == '0);
        full_d         = (level_d == LW'(DEPTH));
        almost_full_d  = (level_d >= LW'(ALMOST_FULL_LEVEL));
        almost_empty_d = (level_d <= LW'(ALMOST_EMPTY_LEVEL));
    end

    always_ff @(posedge clock_port) begin
        if (reset_port) begin
            push_addr_q    <= '0;
            pop_addr_q     <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            fwd_sel_q      <= 1'b0;
        end else begin
            push_addr_q    <= push_addr_d;
            pop_addr_q     <= pop_addr_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            fwd_sel_q      <= fwd_sel_d;
        end
        fwd_dat_q <= fwd_dat_d;
    end

    rv_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk            (clock_port),
        .port1_write_en (mem_wr_en),
        .port1_addr     (push_addr_q),
        .port1_data     (input_port_data),
        .port2_addr     (pop_addr_d),
        .port2_data     (mem_rd_dat)
    );

    assign stored_dat = fwd_sel_q ? fwd_dat_q : mem_rd_dat;

`ifdef RV_FIFO_BYPASS_EN
    assign output_port_valid = ~empty_q | input_port_valid;
    assign output_port_data  = empty_q ? input_port_data : stored_dat;
`else
    assign output_port_valid = ~empty_q;
    assign output_port_data  = stored_dat;
`endif

    assign input_port_ready = ~full_q;
    assign level            = level_q;
    assign almost_full      = almost_full_q;
    assign almost_empty     = almost_empty_q;

endmodule

// File: tb/tb_rv_fifo_level.sv
// Bench for rv_fifo_level (WIDTH=8, DEPTH=10, AF=8, AE=2) against a queue-based reference model.
module tb_rv_fifo_level;

    localparam int DEPTH = 10;
    localparam int AFL   = 8;
    localparam int AEL   = 2;
`ifdef RV_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] in_dat = 8'h00;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic [7:0] out_dat;
    logic       out_vld;
    logic       out_rdy = 1'b0;
    logic [3:0] lvl;
    logic       af, ae;

    int errors = 0;
    int checks = 0;
    logic [7:0] mq[$];

    always #5 clk = ~clk;

    rv_fifo_level #(
        .WIDTH(8), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
    ) dut (
        .clock_port        (clk),
        .reset_port        (rst),
        .clear             (clr),
        .input_port_data   (in_dat),
        .input_port_valid  (in_vld),
        .input_port_ready  (in_rdy),
        .output_port_data  (out_dat),
        .output_port_valid (out_vld),
        .output_port_ready (out_rdy),
        .level             (lvl),
        .almost_full       (af),
        .almost_empty      (ae)
    );

    function automatic bit exp_valid();
        return (mq.size() > 0) || (BYP && in_vld);
    endfunction

    function automatic logic [7:0] exp_data();
        return (mq.size() > 0) ? mq[0] : in_dat;
    endfunction

    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
        in_vld = v; in_dat = d; out_rdy = r; clr = c;
        #1;
    endtask

    // Advance one clock edge and apply the FIFO rules to the reference queue.
    task automatic tick();
        int sz;
        bit byp_take, do_push, do_pop;
        logic [7:0] d;
        sz       = mq.size();
        byp_take = BYP && sz == 0 && in_vld && out_rdy;
        do_pop   = sz > 0 && out_rdy;
        do_push  = in_vld && sz < DEPTH && !byp_take;
        d        = in_dat;
        @(posedge clk);
        #1;
        if (rst || clr) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
    endtask

    task automatic drain();
        drive(0, 8'h00, 1, 0);
        for (int i = 0; i < 2 * DEPTH && mq.size() > 0; i++) tick();
        drive(0, 8'h00, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 8'h00, 0, 0);
        tick(); tick();
        rst = 1'b0;
        checks++; if (lvl !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", lvl); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_vld); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_rdy); end
        checks++; if (ae !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", ae); end
        checks++; if (af !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", af); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 8'(i), 0, 0);
            tick();
            checks++; if (lvl !== 4'(i)) begin errors++; $display("FAIL fill_level: got %0d expected %0d", lvl, i); end
            checks++; if (ae !== (i <= AEL)) begin errors++; $display("FAIL fill_ae at %0d: got %b", i, ae); end
            checks++; if (af !== (i >= AFL)) begin errors++; $display("FAIL fill_af at %0d: got %b", i, af); end
            checks++; if (in_rdy !== (i < DEPTH)) begin errors++; $display("FAIL fill_ready at %0d: got %b", i, in_rdy); end
            checks++; if (out_vld !== 1'b1 || out_dat !== 8'h01) begin
                errors++; $display("FAIL fill_head: got vld=%b dat=%0h expected vld=1 dat=01", out_vld, out_dat); end
        end
    endtask

    task automatic test_full_pop();
        drive(1, 8'h0B, 1, 0);
        checks++; if (in_rdy !== 1'b0 || out_dat !== 8'h01) begin
            errors++; $display("FAIL full_pop_pre: got rdy=%b dat=%0h expected rdy=0 dat=01", in_rdy, out_dat); end
        tick();
        checks++; if (lvl !== 4'd9 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL full_pop_post: got lvl=%0d rdy=%b expected lvl=9 rdy=1", lvl, in_rdy); end
        checks++; if (out_dat !== 8'h02) begin errors++; $display("FAIL full_pop_next: got %0h expected 02", out_dat); end
        tick();
        checks++; if (lvl !== 4'd9 || out_dat !== 8'h03) begin
            errors++; $display("FAIL push_pop_9: got lvl=%0d dat=%0h expected lvl=9 dat=03", lvl, out_dat); end
        checks++; if (mq[mq.size()-1] !== 8'h0B) begin errors++; $display("FAIL model_tail: got %0h expected 0b", mq[mq.size()-1]); end
        drain();
        checks++; if (out_vld !== 1'b0 || lvl !== 4'd0) begin
            errors++; $display("FAIL drain: got vld=%b lvl=%0d expected 0/0", out_vld, lvl); end
    endtask

    task automatic test_empty_push();
        drive(1, 8'h55, 1, 0);
        if (BYP) begin
            checks++; if (out_vld !== 1'b1 || out_dat !== 8'h55) begin
                errors++; $display("FAIL bypass_now: got vld=%b dat=%0h expected 1/55", out_vld, out_dat); end
        end else begin
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL empty_no_bypass: got vld=%b expected 0", out_vld); end
        end
        tick();
        drive(0, 8'h00, 1, 0);
        if (BYP) begin
            checks++; if (lvl !== 4'd0 || out_vld !== 1'b0) begin
                errors++; $display("FAIL bypass_level: got lvl=%0d vld=%b expected 0/0", lvl, out_vld); end
        end else begin
            checks++; if (out_vld !== 1'b1 || out_dat !== 8'h55 || lvl !== 4'd1) begin
                errors++; $display("FAIL latency1: got vld=%b dat=%0h lvl=%0d expected 1/55/1", out_vld, out_dat, lvl); end
        end
        drain();
    endtask

    task automatic test_stream();
        int nout = 0;
        for (int i = 0; i < 25; i++) begin
            drive(1, 8'(i), 1, 0);
            if (out_vld) begin
                checks++; if (out_dat !== 8'(nout)) begin
                    errors++; $display("FAIL stream_order: got %0h expected %0h", out_dat, nout); end
                nout++;
            end
            tick();
            checks++; if (lvl !== (BYP ? 4'd0 : 4'd1)) begin
                errors++; $display("FAIL stream_level: got %0d expected %0d", lvl, BYP ? 0 : 1); end
        end
        checks++; if (nout !== (BYP ? 25 : 24)) begin
            errors++; $display("FAIL stream_count: got %0d expected %0d", nout, BYP ? 25 : 24); end
        drain();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'h11 + 8'(i), 0, 0);
            tick();
        end
        checks++; if (lvl !== 4'd6) begin errors++; $display("FAIL clear_pre: got %0d expected 6", lvl); end
        drive(1, 8'h17, 1, 1);
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (lvl !== 4'd0 || out_vld !== 1'b0) begin
            errors++; $display("FAIL clear_post: got lvl=%0d vld=%b expected 0/0", lvl, out_vld); end
        checks++; if (ae !== 1'b1 || af !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL clear_flags: got ae=%b af=%b rdy=%b expected 1/0/1", ae, af, in_rdy); end
        drive(1, 8'hA1, 0, 0);
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (out_dat !== 8'hA1 || lvl !== 4'd1) begin
            errors++; $display("FAIL clear_first: got dat=%0h lvl=%0d expected a1/1", out_dat, lvl); end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h21 + 8'(i), 0, 0);
            tick();
        end
        rst = 1'b1;
        drive(1, 8'h26, 1, 0);
        tick();
        rst = 1'b0;
        drive(0, 8'h00, 0, 0);
        checks++; if (lvl !== 4'd0 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL rstmid_state: got lvl=%0d vld=%b rdy=%b expected 0/0/1", lvl, out_vld, in_rdy); end
        checks++; if (ae !== 1'b1 || af !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags: got ae=%b af=%b expected 1/0", ae, af); end
        drive(1, 8'hC3, 0, 0);
        tick();
        drive(0, 8'h00, 0, 0);
        checks++; if (out_vld !== 1'b1 || out_dat !== 8'hC3) begin
            errors++; $display("FAIL rstmid_first: got vld=%b dat=%0h expected 1/c3", out_vld, out_dat); end
        drain();
    endtask

    task automatic test_random();
        int pv, pr;
        for (int c = 0; c < 600; c++) begin
            case (c / 150)
                0:       begin pv = 80; pr = 30; end
                1:       begin pv = 30; pr = 80; end
                2:       begin pv = 60; pr = 60; end
                default: begin pv = 90; pr = 90; end
            endcase
            drive($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < pr, $urandom_range(99) == 0);
            checks++; if (out_vld !== exp_valid()) begin
                errors++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, out_vld, exp_valid()); end
            if (exp_valid()) begin
                checks++; if (out_dat !== exp_data()) begin
                    errors++; $display("FAIL rand_data c=%0d: got %0h expected %0h", c, out_dat, exp_data()); end
            end
            checks++; if (lvl !== 4'(mq.size()) || in_rdy !== (mq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_level c=%0d: got lvl=%0d rdy=%b expected %0d", c, lvl, in_rdy, mq.size()); end
            checks++; if (af !== (mq.size() >= AFL) || ae !== (mq.size() <= AEL)) begin
                errors++; $display("FAIL rand_flags c=%0d: got af=%b ae=%b size=%0d", c, af, ae, mq.size()); end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_pop();
        test_empty_push();
        test_stream();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
